// File: rtl/ps2_rx_ctrl_if.sv
// Holding-register side of the PS/2 receiver: byte, write strobe,
// error pulse and frame-in-progress flag.
interface ps2_rx_ctrl_if;
    logic [7:0] reg_data;
    logic       reg_ena;
    logic       frame_err;
    logic       busy;

    modport master (output reg_data, output reg_ena, output frame_err, output busy);
    modport slave  (input  reg_data, input  reg_ena, input  frame_err, input  busy);
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizes the raw lines, assembles an
// 11-bit frame on PS/2 clock falls, checks odd parity and stop, and
// writes good bytes into the downstream holding register.
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    input  logic            rx_en,
    ps2_rx_ctrl_if.master   hreg
);
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES - 1);

    // Synchronizers reset high so the idle-high lines never show a false fall.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            stop_q, stop_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      reg_data_q, reg_data_d;
    logic            reg_ena_q, reg_ena_d;
    logic            frame_err_q, frame_err_d;

    logic fall;
    logic dbit;

    assign fall = clk_prev_q & ~clk_s2_q;
    assign dbit = dat_s2_q;

    // Two-flop synchronizers plus a delayed copy of the synced clock for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            to_q        <= '0;
            reg_data_q  <= '0;
            reg_ena_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            to_q        <= to_d;
            reg_data_q  <= reg_data_d;
            reg_ena_q   <= reg_ena_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: frame assembly on falls, inter-edge timeout, one-cycle check.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_d      = stop_q;
        to_d        = to_q;
        reg_data_d  = reg_data_q;
        reg_ena_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && fall && !dbit) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    to_d      = '0;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    // Silent abort: the frame is simply dropped.
                    state_d = IDLE;
                end else if (fall) begin
                    to_d      = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        shift_d = {dbit, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = dbit;
                    end else begin
                        stop_d  = dbit;
                        state_d = CHECK;
                    end
                end else if (to_q == TO_LIM) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((^{shift_q, par_q}) && stop_q) begin
                    reg_data_d = shift_q;
                    reg_ena_d  = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hreg.reg_data  = reg_data_q;
    assign hreg.reg_ena   = reg_ena_q;
    assign hreg.frame_err = frame_err_q;
    assign hreg.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: bit-banged PS/2 frames, a scoreboard of
// expected strobes (kind, byte, exact cycle) checked by a strobe monitor.
module tb_ps2_rx_ctrl;
    localparam int TO_CYC = 200;
    localparam int K_ENA  = 1;
    localparam int K_ERR  = 2;
    // Input driven just after posedge k: synced fall seen in cycle k+2,
    // CHECK in k+3, strobe in k+4.
    localparam int LAT_FRAME = 4;
    // Last fall in cycle k+2 clears the counter; it reads j in cycle k+3+j,
    // hits TO_CYC-1 in k+2+TO_CYC, error pulse in k+3+TO_CYC.
    localparam int LAT_TO = TO_CYC + 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic rx_en = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    ps2_rx_ctrl_if hreg ();

    ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_en    (rx_en),
        .hreg     (hreg.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // Sends the first nbits bits of a frame; pushes an expectation at the
    // last fall when kind != 0; optionally checks busy after the first bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int kind,
                             input logic [7:0] d, input bit chk_busy, input logic exp_busy);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            repeat (20) @(posedge clk);
            #1 ps2_data = bits[i];
            repeat (20) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == nbits - 1 && kind != 0) begin
                e.kind = kind;
                e.data = d;
                e.cyc  = cyc + ((kind == K_ERR && nbits < 11) ? LAT_TO : LAT_FRAME);
                sbq.push_back(e);
            end
            repeat (40) @(posedge clk);
            if (i == 0 && chk_busy) check("busy_in_frame", 32'(hreg.busy), 32'(exp_busy));
            #1 ps2_clk = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1 ps2_data = 1'b1;
    endtask

    // Strobe monitor: every reg_ena / frame_err must match the scoreboard head.
    always @(negedge clk) begin
        if (hreg.reg_ena || hreg.frame_err) begin
            check("strobe_excl", 32'(hreg.reg_ena & hreg.frame_err), 32'd0);
            if (sbq.size() == 0) begin
                check("unexp_strobe", 32'({hreg.reg_ena, hreg.frame_err}), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("strobe_kind", hreg.reg_ena ? K_ENA : K_ERR, 32'(e.kind));
                check("strobe_cyc", 32'(cyc), 32'(e.cyc));
                if (e.kind == K_ENA) check("strobe_data", 32'(hreg.reg_data), 32'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(hreg.reg_data), 32'h00);
        check("rst_ena",  32'(hreg.reg_ena), 32'd0);
        check("rst_err",  32'(hreg.frame_err), 32'd0);
        check("rst_busy", 32'(hreg.busy), 32'd0);

        // 1: good frame 0x67
        send_bits(mk(8'h67, 1'b0, 1'b1), 11, K_ENA, 8'h67, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t1_data", 32'(hreg.reg_data), 32'h67);
        check("t1_busy", 32'(hreg.busy), 32'd0);

        // 2: parity error
        send_bits(mk(8'hF4, 1'b1, 1'b1), 11, K_ERR, 8'h00, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t2_data_held", 32'(hreg.reg_data), 32'h67);

        // 3: stop-bit error
        send_bits(mk(8'h12, 1'b1, 1'b0), 11, K_ERR, 8'h00, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t3_data_held", 32'(hreg.reg_data), 32'h67);

        // 4: stall after 4 data bits, then a good 0x34
        send_bits(mk(8'h0A, 1'b0, 1'b1), 5, K_ERR, 8'h00, 1'b0, 1'b0);
        repeat (TO_CYC + 20) @(negedge clk);
        check("t4_busy", 32'(hreg.busy), 32'd0);
        send_bits(mk(8'h34, 1'b0, 1'b1), 11, K_ENA, 8'h34, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t4_data", 32'(hreg.reg_data), 32'h34);

        // 5: reset after 5 data bits, then a good 0x56
        send_bits(mk(8'h1F, 1'b0, 1'b1), 6, 0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_data", 32'(hreg.reg_data), 32'h00);
        check("t5_ena",  32'(hreg.reg_ena), 32'd0);
        check("t5_err",  32'(hreg.frame_err), 32'd0);
        check("t5_busy", 32'(hreg.busy), 32'd0);
        send_bits(mk(8'h56, 1'b1, 1'b1), 11, K_ENA, 8'h56, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t5_data2", 32'(hreg.reg_data), 32'h56);

        // 6: receiver disabled, then a lone fall with data high
        #1 rx_en = 1'b0;
        send_bits(mk(8'hA5, 1'b1, 1'b1), 11, 0, 8'h00, 1'b1, 1'b0);
        #1 rx_en = 1'b1;
        send_bits(11'h7FF, 1, 0, 8'h00, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("t6_busy", 32'(hreg.busy), 32'd0);
        check("t6_data", 32'(hreg.reg_data), 32'h56);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
- Receive-side controller for the PS/2 keyboard path.
- Samples the asynchronous PS/2 clock/data lines, assembles an 11-bit frame (start, 8 data LSB-first, odd parity, stop) and checks it.
- On a good frame, sequences the downstream 8-bit holding register: drives its data input and a one-cycle enable strobe.
- Bad or stalled frames raise an error pulse and never touch the register.

Parameters:
- TIMEOUT_CYCLES, 100000: max clk cycles allowed between consecutive PS/2 falling edges inside a frame before the frame is aborted.
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous, idles high.
- ps2_data  in  1  raw PS/2 data line, asynchronous, idles high.
- rx_en  in  1  receive enable; 0 = ignore or abort frames.
- reg_data  out  8  byte to holding register DataIn; updates only on good frames.
- reg_ena  out  1  one-cycle write strobe to holding register ena.
- frame_err  out  1  one-cycle pulse on parity/stop/timeout failure.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is synchronous and active-high.
  - rst=1 at a rising edge: state=IDLE; reg_data=0x00; reg_ena=0; frame_err=0; busy=0; bit counter, shift register and timeout counter=0.
  - Both synchronizer chains reset to 1 so no false edge appears after reset.
  - rst mid-frame discards the partial frame with no reg_ena and no frame_err.
- Input synchronization:
  - 2-flop synchronizer on each of ps2_clk and ps2_data.
  - Falling edge = previous synced clk 1 AND current synced clk 0; one-cycle internal fall pulse.
  - Data is sampled from the synced ps2_data in the fall cycle.
- FSM states: IDLE, RECV, CHECK.
- IDLE:
  - fall with data=0 and rx_en=1: go to RECV, bit_cnt=0, timeout=0.
  - fall with data=1: ignored, stay in IDLE.
  - rx_en=0: all edges ignored.
- RECV:
  - Each fall stores a bit: bit_cnt 0-7 shift into data[7:0] LSB-first, bit_cnt 8 = parity, bit_cnt 9 = stop. bit_cnt increments on each fall.
  - After the stop sample (fall with bit_cnt=9), go to CHECK.
  - Timeout counter clears on every fall and increments otherwise. Reaching TIMEOUT_CYCLES-1 with no fall: frame_err pulse next cycle, go to IDLE.
  - rx_en dropping to 0 in RECV: abort to IDLE next cycle, no reg_ena, no frame_err.
- CHECK (exactly one cycle), then go to IDLE:
  - Good frame: XOR(data[7:0], parity)=1 AND stop=1. Register reg_data<=data and reg_ena=1 for one cycle.
  - Otherwise: frame_err=1 for one cycle; reg_data unchanged.
- Latency: if the stop-bit fall is in cycle E, CHECK is cycle E+1, and reg_ena or frame_err is high during cycle E+2 only. reg_data is valid from E+2 and held until the next good frame.
- Exclusivity: reg_ena and frame_err are never high together. At most one of them pulses per frame.
- busy: 1 from the cycle after the start-bit fall through CHECK; 0 in IDLE.
- Back-to-back frames: a start-bit fall arriving in cycle E+2 is accepted, since the FSM is already in IDLE.

Test Plan:
(Bench: TIMEOUT_CYCLES=200; PS/2 clock period 80 clk cycles, data changes mid-high.)
1. Frame byte 0x67, parity 0, stop 1 -> reg_data=0x67; reg_ena high exactly one cycle, two clk after the stop fall; frame_err stays 0; busy low afterwards.
2. Frame 0xF4 with wrong parity 1 -> frame_err one-cycle pulse; reg_ena stays 0; reg_data stays 0x67.
3. Frame 0x12, parity 1, stop bit 0 -> frame_err pulse; no reg_ena.
4. Start bit plus 4 data bits, then ps2_clk held high -> frame_err pulse ~200 cycles after the last fall; busy drops. A following 0x34 frame (parity 0) gives reg_data=0x34 with one reg_ena.
5. rst=1 for one cycle after 5 data bits -> next cycle all outputs 0, busy=0, no strobes. A following 0x56 frame (parity 1) gives reg_data=0x56.
6. Full valid frame with rx_en=0, plus a lone falling edge with ps2_data=1 in IDLE -> no reg_ena, no frame_err, busy stays 0.
